alarm_tone_gen: RTL and testbench

ALARM_TONE_GEN -- requirements
Module: alarm_tone_gen

---
 rtl/alarm_tone_gen.sv | 137 +++++++++++++
 tb/tb_alarm_tone_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alarm_tone_gen.sv
// Alarm tone generator: cadenced square-wave beeps mixed into an audio sample stream.
// Settings are latched at start; the tone is added to every channel on each sample strobe.
module alarm_tone_gen #(
  parameter int DATA_W    = 32,
  parameter int NUM_CH    = 2,
  parameter int AMPLITUDE = 10000000,
  parameter int TONE_W    = 20,
  parameter int CAD_W     = 27,
  parameter int SATURATE  = 1
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic [TONE_W-1:0]        tone_half,
  input  logic [CAD_W-1:0]         on_len,
  input  logic [CAD_W-1:0]         off_len,
  input  logic [7:0]               beep_count,
  input  logic                     sample_strobe,
  input  logic [NUM_CH*DATA_W-1:0] mix_in,
  output logic [NUM_CH*DATA_W-1:0] mix_out,
  output logic                     busy,
  output logic                     tone_on,
  output logic                     done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ON   = 2'd1;
  localparam logic [1:0] OFF  = 2'd2;

  localparam logic [DATA_W:0] AMP = (DATA_W+1)'(AMPLITUDE);

  logic [1:0]              state;
  logic [CAD_W-1:0]        cad_cnt;
  logic [TONE_W-1:0]       tone_cnt;
  logic                    phase_neg;
  logic [7:0]              remaining;
  logic [TONE_W-1:0]       tone_half_q;
  logic [CAD_W-1:0]        on_len_q;
  logic [CAD_W-1:0]        off_len_q;
  logic [7:0]              beep_count_q;
  logic [DATA_W:0]         tone_val;
  logic [NUM_CH*DATA_W-1:0] mix_next;

  assign busy    = (state == ON) || (state == OFF);
  assign tone_on = (state == ON);

  always_comb begin
    tone_val = '0;
    if (state == ON) tone_val = phase_neg ? -AMP : AMP;
  end

  // Sum at DATA_W+1 bits; overflow shows as disagreement of the top two bits.
  always_comb begin
    logic [DATA_W:0] sum;
    sum      = '0;
    mix_next = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      sum = {mix_in[c*DATA_W+DATA_W-1], mix_in[c*DATA_W +: DATA_W]} + tone_val;
      if ((SATURATE != 0) && (sum[DATA_W] != sum[DATA_W-1]))
        mix_next[c*DATA_W +: DATA_W] = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                                   : {1'b0, {(DATA_W-1){1'b1}}};
      else
        mix_next[c*DATA_W +: DATA_W] = sum[DATA_W-1:0];
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state        <= IDLE;
      cad_cnt      <= '0;
      tone_cnt     <= '0;
      phase_neg    <= 1'b0;
      remaining    <= '0;
      tone_half_q  <= '0;
      on_len_q     <= '0;
      off_len_q    <= '0;
      beep_count_q <= '0;
      mix_out      <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (sample_strobe) mix_out <= mix_next;
      if (stop) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              tone_half_q  <= tone_half;
              on_len_q     <= on_len;
              off_len_q    <= off_len;
              beep_count_q <= beep_count;
              remaining    <= beep_count;
              cad_cnt      <= '0;
              tone_cnt     <= '0;
              phase_neg    <= 1'b0;
              state        <= ON;
            end
          end
          ON: begin
            if (tone_cnt == tone_half_q) begin
              tone_cnt  <= '0;
              phase_neg <= ~phase_neg;
            end else begin
              tone_cnt <= tone_cnt + 1'b1;
            end
            if (cad_cnt == on_len_q) begin
              cad_cnt <= '0;
              if ((beep_count_q != 8'd0) && (remaining == 8'd1)) begin
                state <= IDLE;
                done  <= 1'b1;
              end else begin
                state <= OFF;
                if (beep_count_q != 8'd0) remaining <= remaining - 8'd1;
              end
            end else begin
              cad_cnt <= cad_cnt + 1'b1;
            end
          end
          OFF: begin
            if (cad_cnt == off_len_q) begin
              state     <= ON;
              cad_cnt   <= '0;
              tone_cnt  <= '0;
              phase_neg <= 1'b0;
            end else begin
              cad_cnt <= cad_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alarm_tone_gen.sv
// Directed bench for alarm_tone_gen: mix path table, cadence/phase sequences,
// saturation vs wrap, stop/start priority and reset abort.
module tb_alarm_tone_gen;

  localparam int          A    = 10000000;
  localparam logic [31:0] POS  = 32'h00989680;
  localparam logic [31:0] NEG  = 32'hFF676980;

  logic        CLOCK_50 = 1'b0;
  logic        reset, start, stop, sample_strobe;
  logic [19:0] tone_half;
  logic [26:0] on_len, off_len;
  logic [7:0]  beep_count;
  logic [63:0] mix_in;
  logic [63:0] mix_out, mix_out_w;
  logic        busy, tone_on, done, busy_w, tone_on_w, done_w;

  int checks = 0;
  int errors = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  alarm_tone_gen #(.DATA_W(32), .NUM_CH(2), .AMPLITUDE(A), .TONE_W(20), .CAD_W(27), .SATURATE(1)) u_sat (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .stop(stop), .tone_half(tone_half),
    .on_len(on_len), .off_len(off_len), .beep_count(beep_count), .sample_strobe(sample_strobe),
    .mix_in(mix_in), .mix_out(mix_out), .busy(busy), .tone_on(tone_on), .done(done));

  alarm_tone_gen #(.DATA_W(32), .NUM_CH(2), .AMPLITUDE(A), .TONE_W(20), .CAD_W(27), .SATURATE(0)) u_wrap (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .stop(stop), .tone_half(tone_half),
    .on_len(on_len), .off_len(off_len), .beep_count(beep_count), .sample_strobe(sample_strobe),
    .mix_in(mix_in), .mix_out(mix_out_w), .busy(busy_w), .tone_on(tone_on_w), .done(done_w));

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cfg(input int th, input int on, input int off, input int bc);
    tone_half  = 20'(th);
    on_len     = 27'(on);
    off_len    = 27'(off);
    beep_count = 8'(bc);
  endtask

  typedef struct {
    logic        strobe;
    logic [63:0] din;
    logic [63:0] exp;
  } vec_t;

  vec_t vt[5];

  function automatic logic [31:0] tone_model(input int j);
    int rel;
    rel = -1;
    if (j >= 0 && j < 20) rel = j;
    else if (j >= 30 && j < 50) rel = j - 30;
    if (rel < 0) return 32'h0;
    return ((rel / 4) % 2 == 0) ? POS : NEG;
  endfunction

  initial begin
    vt[0] = '{1'b1, 64'h00001234_00000005, 64'h00001234_00000005};
    vt[1] = '{1'b0, 64'hDEADBEEF_CAFEF00D, 64'h00001234_00000005};
    vt[2] = '{1'b1, 64'hFFFFFFFF_80000000, 64'hFFFFFFFF_80000000};
    vt[3] = '{1'b0, 64'h0, 64'hFFFFFFFF_80000000};
    vt[4] = '{1'b1, 64'h7FFFFFFF_00000001, 64'h7FFFFFFF_00000001};

    reset = 1'b1; start = 1'b0; stop = 1'b0; sample_strobe = 1'b0;
    mix_in = 64'h0; cfg(0, 0, 0, 0);
    tick(); tick();
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_tone_on", {63'd0, tone_on}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_mix", mix_out, 64'd0);
    reset = 1'b0;
    tick();

    // Idle pass-through and hold, both saturation modes
    for (int i = 0; i < 5; i++) begin
      sample_strobe = vt[i].strobe;
      mix_in        = vt[i].din;
      tick();
      chk($sformatf("idle_mix_sat[%0d]", i), mix_out, vt[i].exp);
      chk($sformatf("idle_mix_wrap[%0d]", i), mix_out_w, vt[i].exp);
    end

    // Finite sequence: 2 beeps, 20 on / 10 off, half-period 4
    mix_in = 64'h0; sample_strobe = 1'b1;
    cfg(3, 19, 9, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 53; k++) begin
      logic exp_on;
      logic [31:0] t;
      exp_on = (k < 20) || (k >= 30 && k < 50);
      t = tone_model(k - 1);
      chk($sformatf("seq_tone_on[%0d]", k), {63'd0, tone_on}, {63'd0, exp_on});
      chk($sformatf("seq_done[%0d]", k), {63'd0, done}, {63'd0, (k == 50)});
      chk($sformatf("seq_mix[%0d]", k), mix_out, {t, t});
      tick();
    end

    // Continuous cadence 5/5; a start while busy must not alter settings
    sample_strobe = 1'b0;
    cfg(1, 4, 4, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      chk($sformatf("cont_tone_on[%0d]", k), {63'd0, tone_on}, {63'd0, ((k % 10) < 5)});
      chk($sformatf("cont_busy[%0d]", k), {63'd0, busy}, 64'd1);
      chk($sformatf("cont_done[%0d]", k), {63'd0, done}, 64'd0);
      if (k == 12) begin start = 1'b1; cfg(0, 1, 1, 1); end
      else start = 1'b0;
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_busy", {63'd0, busy}, 64'd0);
    chk("stop_done", {63'd0, done}, 64'd0);
    tick();
    chk("stop_done_after", {63'd0, done}, 64'd0);

    // Saturation vs wrap: tone_half=0 gives + then - on consecutive ON cycles
    cfg(0, 100, 10, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    sample_strobe = 1'b1;
    mix_in = 64'h80000000_7FFFFFFF;
    tick();
    chk("sat_pos", mix_out, 64'h80989680_7FFFFFFF);
    chk("wrap_pos", mix_out_w, 64'h80989680_8098967F);
    mix_in = 64'h00000005_80000000;
    tick();
    chk("sat_neg", mix_out, 64'hFF676985_80000000);
    chk("wrap_neg", mix_out_w, 64'hFF676985_7F676980);
    sample_strobe = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // start and stop together in IDLE: stop wins
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("start_stop_busy", {63'd0, busy}, 64'd0);

    // Reset during ON aborts without done; restart behaves as fresh
    cfg(2, 5, 3, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    sample_strobe = 1'b1; mix_in = 64'h00000001_00000001;
    tick(); tick();
    sample_strobe = 1'b0;
    chk("pre_reset_mix", mix_out, {POS + 32'd1, POS + 32'd1});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_mix", mix_out, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rst_no_done[%0d]", k), {63'd0, done}, 64'd0);
      tick();
    end
    cfg(0, 2, 2, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("restart_tone_on[%0d]", k), {63'd0, tone_on}, {63'd0, (k < 3)});
      chk($sformatf("restart_done[%0d]", k), {63'd0, done}, {63'd0, (k == 3)});
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
